// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES word type, round constants and S-box helpers
package aes_pkg;

  typedef logic [31:0] word_t;

  // Rcon[1] sits in the top byte, Rcon[10] in the bottom byte
  localparam logic [79:0] RCON = 80'h01_02_04_08_10_20_40_80_1b_36;

  function automatic int nr(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      if (idx == 4'(i)) r = RCON[8*(10-i) +: 8];
    end
    return r;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as x^254 (product of x^2..x^128), then the FIPS affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic word_t sub_word(input word_t x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

endpackage

// File: rtl/invkeysched_g.sv
// rtl/invkeysched_g.sv - key expansion g() function selected by word index j
module invkeysched_g
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  word_t      x_i,
  input  logic [5:0] j_i,
  output word_t      g_o
);

  logic [5:0] j_mod;
  logic [3:0] j_div;
  word_t      sub_in;
  word_t      sub_out;

  assign j_mod   = j_i % 6'(NK);
  assign j_div   = 4'(j_i / 6'(NK));
  assign sub_in  = (j_mod == 6'd0) ? {x_i[23:0], x_i[31:24]} : x_i;
  assign sub_out = sub_word(sub_in);

  always_comb begin
    if (j_mod == 6'd0) begin
      g_o = sub_out ^ {rcon(j_div), 24'h000000};
    end else if (NK == 8 && j_mod == 6'd4) begin
      g_o = sub_out;
    end else begin
      g_o = x_i;
    end
  end

endmodule

// File: rtl/invkeysched_iter.sv
// rtl/invkeysched_iter.sv - iterative inverse AES key schedule, round keys Nr..0 on a stream
module invkeysched_iter
  import aes_pkg::*;
#(
  parameter int WORD = 32,
  parameter int NB   = 4,
  parameter int NK   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [WORD*NK-1:0]   i_key,
  output logic                 o_rk_valid,
  input  logic                 i_rk_ready,
  output logic [WORD*NB-1:0]   o_rk,
  output logic [3:0]           o_rk_idx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int NR = nr(NK);
  localparam int NW = 4 * (NR + 1);
  localparam int KW = WORD * NB;

  if (WORD != 32 || NB != 4) begin : g_bad_shape
    $error("invkeysched_iter: WORD must be 32 and NB must be 4");
  end
  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("invkeysched_iter: NK must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {IDLE, EMIT, STEP, DONE} state_t;

  state_t             state_q;
  logic [WORD*NK-1:0] win_q;
  logic [5:0]         l_q;
  logic [3:0]         r_q;
  logic [KW-1:0]      rk_q;
  logic [3:0]         idx_q;
  logic               valid_q, busy_q, done_q;

  // Window W[0] lives in the MSBs, matching the i_key layout
  logic [WORD*NK-1:0] shift_win;
  logic [5:0]         j;
  word_t              g_out, new_word;
  logic [6:0]         r4_cur, r4_dec, l_ext, l_dec, off_hold, off_step;
  logic               hold_ok, step_ok;
  logic [KW-1:0]      rk_hold, rk_step;

  assign j = l_q + 6'(NK - 1);

  invkeysched_g #(.NK(NK)) u_g (
    .x_i (win_q[2*WORD-1 -: WORD]),
    .j_i (j),
    .g_o (g_out)
  );

  assign new_word  = win_q[WORD-1:0] ^ g_out;
  assign shift_win = {new_word, win_q[WORD*NK-1:WORD]};

  assign r4_cur   = {1'b0, r_q, 2'b00};
  assign r4_dec   = {1'b0, r_q - 4'd1, 2'b00};
  assign l_ext    = {1'b0, l_q};
  assign l_dec    = l_ext - 7'd1;
  assign off_hold = r4_dec - l_ext;
  assign off_step = r4_cur - l_dec;
  assign hold_ok  = (r4_dec >= l_ext);
  assign step_ok  = (r4_cur >= l_dec);

  always_comb begin
    rk_hold = '0;
    rk_step = '0;
    for (int o = 0; o <= NK - 4; o++) begin
      if (off_hold == 7'(o)) rk_hold = win_q[WORD*(NK-4-o) +: KW];
      if (off_step == 7'(o)) rk_step = shift_win[WORD*(NK-4-o) +: KW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      rk_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_load) begin
            state_q <= EMIT;
            win_q   <= i_key;
            l_q     <= 6'(NW - NK);
            r_q     <= 4'(NR);
            rk_q    <= i_key[KW-1:0];
            idx_q   <= 4'(NR);
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        EMIT: begin
          if (i_rk_ready) begin
            if (r_q == 4'd0) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              r_q <= r_q - 4'd1;
              if (hold_ok) begin
                rk_q  <= rk_hold;
                idx_q <= r_q - 4'd1;
              end else begin
                state_q <= STEP;
                valid_q <= 1'b0;
              end
            end
          end
        end
        STEP: begin
          win_q <= shift_win;
          l_q   <= l_q - 6'd1;
          if (step_ok) begin
            state_q <= EMIT;
            rk_q    <= rk_step;
            idx_q   <= r_q;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_rk_valid = valid_q;
  assign o_rk       = rk_q;
  assign o_rk_idx   = idx_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule
